// File: rtl/tetris_move_search.sv
// tetris_move_search: sweeps every (rotation, column) placement of the latched
// piece, hard-drops each legal one row by row, presents the landed board to an
// external combinational scorer and keeps the lowest-scoring candidate.
module tetris_move_search #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   board,
  input  logic [2:0]             piece,
  output logic [ROWS*COLS-1:0]   cand_board,
  input  logic [31:0]            cand_score,
  output logic                   busy,
  output logic                   done,
  output logic                   best_valid,
  output logic [1:0]             best_rot,
  output logic [3:0]             best_col,
  output logic [31:0]            best_score
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);

  typedef enum logic [2:0] {IDLE, SETUP, DROP, SCORE, NEXT, DONE} state_t;

  state_t             state, state_d;
  logic [CELLS-1:0]   board_q;
  logic [2:0]         piece_q;
  logic [1:0]         rot;
  logic [3:0]         col;
  logic [4:0]         row;

  // 4x4 shape mask; rotations packed {rot3, rot2, rot1, rot0}, each normalised
  // so the minimum occupied row and column are 0.
  function automatic logic [15:0] shape_mask(input logic [2:0] p, input logic [1:0] r);
    logic [63:0] t;
    case (p)
      3'd0:    t = {16'h1111, 16'h000F, 16'h1111, 16'h000F};  // I
      3'd1:    t = {4{16'h0033}};                             // O
      3'd2:    t = {16'h0131, 16'h0072, 16'h0232, 16'h0027};  // T
      3'd3:    t = {16'h0231, 16'h0036, 16'h0231, 16'h0036};  // S
      3'd4:    t = {16'h0132, 16'h0063, 16'h0132, 16'h0063};  // Z
      3'd5:    t = {16'h0322, 16'h0047, 16'h0113, 16'h0071};  // J
      3'd6:    t = {16'h0223, 16'h0017, 16'h0311, 16'h0074};  // L
      default: t = '0;                                        // invalid piece
    endcase
    return t[{r, 4'b0000} +: 16];
  endfunction

  // Places a mask with its anchor at (r0, c0); the MSB flags any cell that
  // falls outside the board (such cells are not drawn).
  function automatic logic [CELLS:0] place(input logic [15:0] m, input logic [4:0] r0,
                                           input logic [3:0] c0);
    logic [CELLS-1:0] cells;
    logic             oob;
    int               rr, cc;
    cells = '0;
    oob   = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (m[4*r+c]) begin
          rr = int'(r0) + r;
          cc = int'(c0) + c;
          if (rr > ROWS - 1 || cc > COLS - 1) oob = 1'b1;
          else cells[IW'(COLS * rr + cc)] = 1'b1;
        end
      end
    end
    return {oob, cells};
  endfunction

  logic [15:0]      mask;
  logic [CELLS:0]   cur_place, nxt_place;
  logic             cur_oob, nxt_oob, collide, can_move, last_cand, better;
  logic [CELLS-1:0] cur_cells, nxt_cells;

  assign mask      = shape_mask(piece_q, rot);
  assign cur_place = place(mask, row, col);
  assign nxt_place = place(mask, row + 5'd1, col);
  assign cur_oob   = cur_place[CELLS];
  assign cur_cells = cur_place[CELLS-1:0];
  assign nxt_oob   = nxt_place[CELLS];
  assign nxt_cells = nxt_place[CELLS-1:0];
  assign collide   = |(cur_cells & board_q);
  assign can_move  = !nxt_oob && !(|(nxt_cells & board_q));
  assign last_cand = (rot == 2'd3) && (col == 4'(COLS - 1));
  assign better    = !best_valid || ($signed(cand_score) < $signed(best_score));

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic for the sweep.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    case (state)
      IDLE:  if (start) state_d = SETUP;
      SETUP: state_d = (mask == '0 || cur_oob || collide) ? NEXT : DROP;
      DROP:  if (!can_move) state_d = SCORE;
      SCORE: state_d = NEXT;
      NEXT:  state_d = last_cand ? DONE : SETUP;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: input latch, sweep counters, drop row, candidate board, best tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      board_q    <= '0;
      piece_q    <= '0;
      rot        <= '0;
      col        <= '0;
      row        <= '0;
      cand_board <= '0;
      best_valid <= 1'b0;
      best_rot   <= '0;
      best_col   <= '0;
      best_score <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          board_q    <= board;
          piece_q    <= piece;
          rot        <= '0;
          col        <= '0;
          row        <= '0;
          best_valid <= 1'b0;
          best_rot   <= '0;
          best_col   <= '0;
          best_score <= 32'h7FFF_FFFF;
        end
        DROP: begin
          if (can_move) row <= row + 5'd1;
          else          cand_board <= board_q | cur_cells;
        end
        SCORE: if (better) begin
          best_valid <= 1'b1;
          best_rot   <= rot;
          best_col   <= col;
          best_score <= cand_score;
        end
        NEXT: begin
          row <= '0;
          if (!last_cand) begin
            if (col == 4'(COLS - 1)) begin
              col <= '0;
              rot <= rot + 2'd1;
            end else begin
              col <= col + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_move_search.sv
// Scoreboard bench for tetris_move_search: stimulus pushes the expected search
// result, a negedge monitor pops it on each done pulse. A simple bench-side
// scorer (sum of (20 - row) over occupied cells, minus 100) drives cand_score.
module tb_tetris_move_search;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [199:0] board;
  logic [2:0]   piece;
  logic [199:0] cand_board;
  logic [31:0]  cand_score;
  logic         busy, done, best_valid;
  logic [1:0]   best_rot;
  logic [3:0]   best_col;
  logic [31:0]  best_score;

  tetris_move_search dut (
    .clk(clk), .reset(reset), .start(start), .board(board), .piece(piece),
    .cand_board(cand_board), .cand_score(cand_score), .busy(busy), .done(done),
    .best_valid(best_valid), .best_rot(best_rot), .best_col(best_col),
    .best_score(best_score)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] score_of(input logic [199:0] b);
    int s;
    s = -100;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        if (b[10*r+c]) s += 20 - r;
    return s;
  endfunction

  assign cand_score = score_of(cand_board);

  typedef struct {
    string        name;
    logic         valid;
    logic [1:0]   rot;
    logic [3:0]   col;
    logic [31:0]  score;
    int           busy_cycles;
    logic         chk_cand;
    logic [199:0] cand;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   done_pulses = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles, watches for the expected candidate board,
  // and compares the result on every done pulse.
  initial begin
    int   busy_cnt;
    logic seen;
    exp_t e;
    busy_cnt = 0;
    seen     = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
        seen     = 1'b0;
      end else begin
        if (busy) begin
          busy_cnt++;
          if (q.size() > 0 && q[0].chk_cand && cand_board === q[0].cand) seen = 1'b1;
        end
        if (done) begin
          done_pulses++;
          if (q.size() == 0) begin
            check("unexpected_done", 1'b1, 1'b0);
          end else begin
            e = q.pop_front();
            check({e.name, ".best_valid"}, best_valid, e.valid);
            check({e.name, ".best_rot"},   best_rot,   e.rot);
            check({e.name, ".best_col"},   best_col,   e.col);
            check({e.name, ".best_score"}, best_score, e.score);
            check({e.name, ".busy_cycles"}, busy_cnt,  e.busy_cycles);
            if (e.chk_cand) check({e.name, ".cand_board_seen"}, seen, 1'b1);
          end
          busy_cnt = 0;
          seen     = 1'b0;
        end
      end
    end
  end

  task automatic issue_start(input logic [199:0] b, input logic [2:0] p);
    @(negedge clk);
    board = b;
    piece = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check({name, ".done_in_time"}, got, 1'b1);
  endtask

  task automatic run(input string name, input logic [199:0] b, input logic [2:0] p,
                     input logic v, input logic [1:0] r, input logic [3:0] c,
                     input logic [31:0] s, input int cyc, input logic chk,
                     input logic [199:0] cb);
    exp_t e;
    e = '{name: name, valid: v, rot: r, col: c, score: s, busy_cycles: cyc,
          chk_cand: chk, cand: cb};
    q.push_back(e);
    issue_start(b, p);
    wait_done(name, 3000);
  endtask

  logic [199:0] b_empty, b_row0, b_col0, cb_o, cb_i, cb_col0, all_ones;
  int           pulses_before;

  initial begin
    b_empty = '0;
    b_row0  = '0;
    for (int c = 0; c < 10; c++) b_row0[c] = 1'b1;
    b_col0  = '0;
    for (int r = 10; r < 20; r++) b_col0[10*r] = 1'b1;
    cb_o = '0;
    cb_o[180] = 1'b1; cb_o[181] = 1'b1; cb_o[190] = 1'b1; cb_o[191] = 1'b1;
    cb_i = '0;
    cb_i[169] = 1'b1; cb_i[179] = 1'b1; cb_i[189] = 1'b1; cb_i[199] = 1'b1;
    cb_col0 = b_col0;
    cb_col0[80] = 1'b1; cb_col0[81] = 1'b1; cb_col0[90] = 1'b1; cb_col0[91] = 1'b1;
    all_ones = '1;

    reset = 1'b1;
    start = 1'b0;
    board = '0;
    piece = '0;
    repeat (3) @(negedge clk);
    check("reset.busy",       busy,       1'b0);
    check("reset.done",       done,       1'b0);
    check("reset.best_valid", best_valid, 1'b0);
    check("reset.best_rot",   best_rot,   2'd0);
    check("reset.best_col",   best_col,   4'd0);
    check("reset.best_score", best_score, 32'd0);
    check("reset.cand_board", cand_board, 200'd0);
    reset = 1'b0;

    // Empty board, O: all landings tie at -94; first in sweep order wins.
    run("empty_O", b_empty, 3'd1, 1'b1, 2'd0, 4'd0, -32'sd94, 800, 1'b1, cb_o);
    // Row 0 full, T: every spawn collides.
    run("row0_T", b_row0, 3'd2, 1'b0, 2'd0, 4'd0, 32'h7FFF_FFFF, 80, 1'b0, '0);
    // Invalid piece: empty mask, nothing legal.
    run("piece7", b_empty, 3'd7, 1'b0, 2'd0, 4'd0, 32'h7FFF_FFFF, 80, 1'b0, '0);
    // Empty board, I: horizontal at row 19 scores -96; vertical col 9 must appear.
    run("empty_I", b_empty, 3'd0, 1'b1, 2'd0, 4'd0, -32'sd96, 734, 1'b1, cb_i);
    // Column 0 stack: O at col 0 lands rows 8-9 (+1), col 1 is the signed best (-39).
    run("col0_O", b_col0, 3'd1, 1'b1, 2'd0, 4'd1, -32'sd39, 760, 1'b1, cb_col0);

    // Second start and input changes mid-search must be ignored.
    q.push_back('{name: "restart_ignored", valid: 1'b1, rot: 2'd0, col: 4'd0,
                  score: -32'sd94, busy_cycles: 800, chk_cand: 1'b1, cand: cb_o});
    issue_start(b_empty, 3'd1);
    repeat (100) @(negedge clk);
    board = all_ones;
    piece = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    board = b_row0;
    piece = 3'd7;
    wait_done("restart_ignored", 3000);

    // Reset mid-search: abort to reset values, no done pulse.
    pulses_before = done_pulses;
    issue_start(b_empty, 3'd0);
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort.busy",       busy,       1'b0);
    check("abort.best_valid", best_valid, 1'b0);
    check("abort.best_rot",   best_rot,   2'd0);
    check("abort.best_col",   best_col,   4'd0);
    check("abort.best_score", best_score, 32'd0);
    check("abort.cand_board", cand_board, 200'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort.no_done", done_pulses, pulses_before);

    // A fresh search after the abort completes normally.
    run("after_abort", b_empty, 3'd1, 1'b1, 2'd0, 4'd0, -32'sd94, 800, 1'b1, cb_o);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tetris_move_search.md
# tetris_move_search

Sequential placement search for the current falling piece, sitting directly upstream of the combinational board scorer. On `start` it latches the settled 200-bit board and a piece code. It then sweeps every (rotation, column) candidate and hard-drops each legal one row by row. Each resulting board is presented to the scorer, and the block reports the candidate with the lowest score to the game controller.

## Interface
- `ROWS`, 20: board rows; row 0 is the top row.
- `COLS`, 10: board columns; the cell at (row r, col c) is bit `COLS*r + c`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a search; sampled only in IDLE.
- `board`  in  200  settled board; 1 = occupied; latched on accepted `start`.
- `piece`  in  3  piece code: 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L, 7 invalid; latched on accepted `start`.
- `cand_board`  out  200  registered candidate board, driven to the scorer's board input.
- `cand_score`  in  32  scorer output for `cand_board`; lower is better; compared as signed two's complement.
- `busy`  out  1  high from the cycle after `start` is accepted until the DONE state.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `best_valid`  out  1  at least one legal candidate was found.
- `best_rot`  out  2  rotation of the best candidate.
- `best_col`  out  4  anchor column of the best candidate.
- `best_score`  out  32  score of the best candidate.

## Operation
- Shape ROM: 4x4 mask per (piece, rotation); mask bit `4*r+c` is row offset r (downward), column offset c.
  - Rotation-0 shapes:
    - I: row 0, cols 0-3.
    - O: rows 0-1, cols 0-1.
    - T: row 0 cols 0-2, plus (1,1).
    - S: row 0 cols 1-2, row 1 cols 0-1.
    - Z: row 0 cols 0-1, row 1 cols 1-2.
    - J: (0,0), plus row 1 cols 0-2.
    - L: (0,2), plus row 1 cols 0-2.
  - Rotations 1-3: successive 90° clockwise turns, each shifted so the minimum occupied row and column are 0.
  - Piece 7: empty mask; every candidate is illegal.
- Sweep order: rot 0..3 (outer), col 0..9 (inner). All 40 candidates are visited, including duplicate rotations.
- States and transitions:
  - IDLE: wait for `start`; on start, latch inputs, set rot=0, col=0, `best_valid`=0, `best_score`=32'h7FFFFFFF, then go to SETUP.
  - SETUP: row=0. The candidate is illegal if any occupied cell has col+c > 9, or collides with the board at row 0. Illegal goes to NEXT; the mask is empty (piece 7) also goes to NEXT; otherwise go to DROP.
  - DROP: one cycle per evaluation. The piece can move if every occupied cell at row+1 satisfies row+1+r ≤ 19 and hits a free board cell.
    - If it can move: row ← row+1 and stay in DROP.
    - Otherwise: `cand_board` ← board | mask placed at (row, col), then go to SCORE.
  - SCORE: `cand_board` is stable; sample `cand_score`. If signed `cand_score` < `best_score`, or `best_valid`=0, update `best_score`, `best_rot`, `best_col` and set `best_valid`=1. Then go to NEXT.
  - NEXT: if rot=3 and col=9, go to DONE. Otherwise increment col, wrapping 9→0 with rot+1, and go to SETUP.
  - DONE: `done`=1, `busy`=0; go to IDLE next cycle.
- Tie rule: strict less-than, so the first candidate in sweep order wins ties.
- No legal candidate: `best_valid`=0, `best_rot`=0, `best_col`=0, `best_score`=32'h7FFFFFFF.
- `start` is ignored while not in IDLE. `board` and `piece` changing mid-search have no effect.

## Timing
- Reset values: state IDLE; `busy`, `done`, `best_valid` = 0; `best_rot`, `best_col`, `best_score`, `cand_board` = 0.
- Reset asserted mid-search: aborts next edge to the reset values; no `done` pulse.
- Legal candidate with d row steps costs d+4 cycles: SETUP 1, DROP d+1, SCORE 1, NEXT 1.
- Illegal candidate costs 2 cycles: SETUP, NEXT.
- `busy` high-cycle count equals the sum of per-candidate costs. `done` follows in the next cycle.
- `best_*` outputs are stable from the `done` cycle until the next accepted `start`.
- The scorer is combinational: `cand_score` is valid in the cycle after `cand_board` is registered, i.e. in SCORE.

## Test plan
- Empty board, piece O → `best_valid`=1, `best_rot`=0, `best_col`=0, `best_score`=503736 with default scorer weights. `busy` high 800 cycles: 36 legal × 22 + 4 illegal × 2.
- Row 0 fully occupied, piece T → every spawn collides; `best_valid`=0, `best_score`=32'h7FFFFFFF. `done` after `busy` is high 80 cycles.
- Piece 7 on an empty board → `best_valid`=0; `busy` high 80 cycles.
- Empty board, piece I → horizontal cols 7-9 illegal, vertical col 9 legal. Verify `cand_board` for rot 1, col 9 equals bits 189,179,169,199 set (rows 16-19, col 9).
- Board with col 0 filled at rows 10-19, piece O at rot 0, col 0 → piece stops at rows 8-9 (d=8). That candidate's `cand_board` has bits 80,81,90,91 added.
- `start` pulsed again mid-search → ignored, result unchanged. Reset pulsed mid-search → outputs return to reset values, no `done`; a new `start` completes normally.
